// File: rtl/dpsram_fifo_ctrl.sv
// FIFO controller around an external single-clock 128x13 dual-port SRAM.
// Port A is the write side and port B the read side. Reads have one cycle of
// latency, so a two-entry output buffer plus an in-flight flag keep
// OUT_DATA registered while still moving one sample per cycle.
module dpsram_fifo_ctrl #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] RAM_A_ADDR,
    output logic [DATA_W-1:0] RAM_A_DIN,
    output logic              RAM_A_WEN,
    output logic [ADDR_W-1:0] RAM_B_ADDR,
    output logic [DATA_W-1:0] RAM_B_DIN,
    output logic              RAM_B_WEN,
    input  logic [DATA_W-1:0] RAM_B_DOUT,
    output logic [7:0]        LEVEL,
    output logic              FULL,
    output logic              EMPTY
);

    localparam int CW = ADDR_W + 1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CW-1:0]     r_ram_count;
    logic [1:0]        r_out_count;
    logic              r_rd_inflight;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic              r_out_valid;
    logic [7:0]        r_level;
    logic              r_empty;

    logic              w_full;
    logic              w_accept;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_out_claim;
    logic [1:0]        w_cnt_after_pop;
    logic [1:0]        w_out_count_nxt;
    logic [CW-1:0]     w_ram_count_nxt;
    logic [7:0]        w_level_nxt;
    logic [DATA_W-1:0] w_buf0_nxt;
    logic [DATA_W-1:0] w_buf1_nxt;

    // Write side: IN_READY uses the pre-cycle count, so a same-cycle read
    // issue never opens a slot early.
    assign w_full   = (r_ram_count == CW'(DEPTH));
    assign IN_READY = RESETN & ~w_full & ~FLUSH;
    assign w_accept = IN_VALID & IN_READY;

    // Read side: issue only when the output buffer plus the in-flight read
    // still leaves room after this cycle's pop. A non-empty RAM means
    // rd_ptr != wr_ptr unless full, and full blocks the write, so port A and
    // port B never meet on one address.
    assign w_pop       = r_out_valid & OUT_READY;
    assign w_out_claim = {1'b0, r_out_count} + {2'b0, r_rd_inflight} - {2'b0, w_pop};
    assign w_issue     = (r_ram_count != '0) && (w_out_claim < 3'd2);

    assign RAM_A_WEN  = w_accept;
    assign RAM_A_ADDR = r_wr_ptr;
    assign RAM_A_DIN  = IN_DATA;
    assign RAM_B_ADDR = r_rd_ptr;
    assign RAM_B_DIN  = '0;
    assign RAM_B_WEN  = 1'b0;

    assign w_ram_count_nxt = r_ram_count + CW'(w_accept) - CW'(w_issue);
    assign w_cnt_after_pop = r_out_count - {1'b0, w_pop};
    assign w_out_count_nxt = w_cnt_after_pop + {1'b0, r_rd_inflight};
    assign w_level_nxt     = 8'(w_ram_count_nxt) + {6'b0, w_out_count_nxt} + {7'b0, w_issue};

    // Output buffer next state: shift on pop, then append returning read data
    // behind whatever remains.
    always_comb begin
        w_buf0_nxt = w_pop ? r_buf1 : r_buf0;
        w_buf1_nxt = r_buf1;
        if (r_rd_inflight) begin
            if (w_cnt_after_pop == 2'd0) begin
                w_buf0_nxt = RAM_B_DOUT;
            end else begin
                w_buf1_nxt = RAM_B_DOUT;
            end
        end
    end

    // Pointer, count, buffer and status registers; reset beats flush, and
    // both drop any read still in flight.
    always_ff @(posedge CLK) begin
        if (!RESETN || FLUSH) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_count   <= '0;
            r_out_count   <= '0;
            r_rd_inflight <= 1'b0;
            r_buf0        <= '0;
            r_buf1        <= '0;
            r_out_valid   <= 1'b0;
            r_level       <= '0;
            r_empty       <= 1'b1;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_count   <= w_ram_count_nxt;
            r_rd_inflight <= w_issue;
            r_out_count   <= w_out_count_nxt;
            r_buf0        <= w_buf0_nxt;
            r_buf1        <= w_buf1_nxt;
            r_out_valid   <= (w_out_count_nxt != 2'd0);
            r_level       <= w_level_nxt;
            r_empty       <= (w_level_nxt == 8'd0);
        end
    end

    assign OUT_DATA  = r_buf0;
    assign OUT_VALID = r_out_valid;
    assign LEVEL     = r_level;
    assign FULL      = w_full;
    assign EMPTY     = r_empty;

endmodule

// File: tb/tb_dpsram_fifo_ctrl.sv
// Testbench for dpsram_fifo_ctrl: behavioural 128x13 DPSRAM, a queue
// scoreboard fed by the stimulus and drained by an output monitor, plus
// directed checks on latency, fill level, flush and reset.
module tb_dpsram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        RESETN;
    logic        FLUSH;
    logic [12:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [12:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [6:0]  RAM_A_ADDR;
    logic [12:0] RAM_A_DIN;
    logic        RAM_A_WEN;
    logic [6:0]  RAM_B_ADDR;
    logic [12:0] RAM_B_DIN;
    logic        RAM_B_WEN;
    logic [12:0] RAM_B_DOUT;
    logic [7:0]  LEVEL;
    logic        FULL;
    logic        EMPTY;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [12:0] exp_q[$];
    logic        poison_req;

    always #5 clk = ~clk;

    dpsram_fifo_ctrl #(.DATA_W(13), .ADDR_W(7), .DEPTH(128)) dut (
        .CLK(clk), .RESETN(RESETN), .FLUSH(FLUSH),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RAM_A_ADDR(RAM_A_ADDR), .RAM_A_DIN(RAM_A_DIN), .RAM_A_WEN(RAM_A_WEN),
        .RAM_B_ADDR(RAM_B_ADDR), .RAM_B_DIN(RAM_B_DIN), .RAM_B_WEN(RAM_B_WEN),
        .RAM_B_DOUT(RAM_B_DOUT), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY)
    );

    // Behavioural DPSRAM. Contents are poisoned on flush/reset so that any
    // read of a stale, not-rewritten entry shows up as a scoreboard error.
    logic [12:0] mem [128];
    logic [12:0] r_bq;
    always @(posedge clk) begin
        if (poison_req) begin
            for (int i = 0; i < 128; i++) mem[i] <= 13'h1FFF;
        end
        if (RAM_A_WEN) mem[RAM_A_ADDR] <= RAM_A_DIN;
        r_bq <= mem[RAM_B_ADDR];
    end
    assign RAM_B_DOUT = r_bq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    int n_pops = 0;
    always @(negedge clk) begin
        logic [12:0] e;
        n_chk++;
        if (LEVEL > 8'd130) begin
            n_fail++;
            $display("FAIL level_bound: LEVEL=%0d, limit 130", LEVEL);
        end
        if (OUT_VALID && OUT_READY) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: got 0x%0h, expected no output", OUT_DATA);
            end else begin
                e = exp_q.pop_front();
                chk("scoreboard", 32'(OUT_DATA), 32'(e));
            end
        end
    end

    // Drive one cycle's inputs, then at the negedge record an accepted sample.
    task automatic drive(input logic v, input logic [12:0] d, input logic r);
        IN_VALID  = v;
        IN_DATA   = d;
        OUT_READY = r;
        @(negedge clk);
        if (IN_VALID && IN_READY) exp_q.push_back(d);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            drive(1'b0, 13'h0, 1'b1);
            adv();
            c++;
        end
        chk({nm, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        drive(1'b0, 13'h0, 1'b1);
        chk({nm, "_empty"}, 32'(EMPTY), 32'd1);
        chk({nm, "_level0"}, 32'(LEVEL), 32'd0);
        adv();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stalls;
        int acc;
        int c;
        logic        v;
        logic        r;
        logic [12:0] d;

        // Reset state
        RESETN = 1'b0; FLUSH = 1'b0; poison_req = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 13'h5; OUT_READY = 1'b0;
        adv(); adv();
        drive(1'b1, 13'h5, 1'b0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_data",  32'(OUT_DATA),  32'd0);
        chk("rst_level",     32'(LEVEL),     32'd0);
        chk("rst_full",      32'(FULL),      32'd0);
        chk("rst_empty",     32'(EMPTY),     32'd1);
        chk("rst_a_wen",     32'(RAM_A_WEN), 32'd0);
        chk("rst_in_ready",  32'(IN_READY),  32'd0);
        chk("rst_b_wen",     32'(RAM_B_WEN), 32'd0);
        chk("rst_b_din",     32'(RAM_B_DIN), 32'd0);
        adv();
        RESETN = 1'b1; poison_req = 1'b0;

        // Single sample latency: write at t, issue at t+1, visible at t+3
        drive(1'b1, 13'h001, 1'b1);
        chk("lat_a_wen",  32'(RAM_A_WEN),  32'd1);
        chk("lat_a_addr", 32'(RAM_A_ADDR), 32'd0);
        chk("lat_a_din",  32'(RAM_A_DIN),  32'h1);
        adv();
        drive(1'b0, 13'h0, 1'b1);
        chk("lat_t1_b_addr", 32'(RAM_B_ADDR), 32'd0);
        chk("lat_t1_level",  32'(LEVEL),      32'd1);
        chk("lat_t1_a_wen",  32'(RAM_A_WEN),  32'd0);
        adv();
        drive(1'b0, 13'h0, 1'b1);
        chk("lat_t2_valid", 32'(OUT_VALID), 32'd0);
        chk("lat_t2_level", 32'(LEVEL),     32'd1);
        adv();
        drive(1'b0, 13'h0, 1'b1);
        chk("lat_t3_valid", 32'(OUT_VALID), 32'd1);
        chk("lat_t3_data",  32'(OUT_DATA),  32'h1);
        adv();
        drive(1'b0, 13'h0, 1'b1);
        chk("lat_t4_empty", 32'(EMPTY),     32'd1);
        chk("lat_t4_valid", 32'(OUT_VALID), 32'd0);
        adv();

        // Fill with downstream stalled: 128 in RAM + 2 in the output buffer
        n = 0;
        for (int k = 0; k < 200; k++) begin
            drive(1'b1, 13'(n), 1'b0);
            if (!IN_READY) break;
            n++;
            adv();
        end
        chk("fill_accepts",  32'(n),        32'd130);
        chk("fill_full",     32'(FULL),     32'd1);
        chk("fill_level",    32'(LEVEL),    32'd130);
        chk("fill_in_ready", 32'(IN_READY), 32'd0);
        chk("fill_head",     32'(OUT_DATA), 32'd0);
        adv();
        drain("fill");

        // Continuous streaming, 300 samples, two more pointer wraps
        stalls = 0;
        acc = 0;
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 13'(13'h400 + k), 1'b1);
            if (IN_READY) acc++;
            if (k >= 3 && !OUT_VALID) stalls++;
            adv();
        end
        chk("stream_accepts", 32'(acc),    32'd300);
        chk("stream_stalls",  32'(stalls), 32'd0);
        drain("stream");

        // Flush with LEVEL=5 and one read in flight
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 13'(13'h0F0 + k), 1'b0);
            adv();
        end
        drive(1'b1, 13'h0F5, 1'b1);
        adv();
        FLUSH = 1'b1; poison_req = 1'b1;
        drive(1'b1, 13'h0F6, 1'b0);
        chk("flush_pre_level", 32'(LEVEL),     32'd5);
        chk("flush_in_ready",  32'(IN_READY),  32'd0);
        chk("flush_a_wen",     32'(RAM_A_WEN), 32'd0);
        adv();
        FLUSH = 1'b0; poison_req = 1'b0;
        exp_q.delete();
        drive(1'b1, 13'h0AB, 1'b1);
        chk("flush_level", 32'(LEVEL),      32'd0);
        chk("flush_valid", 32'(OUT_VALID),  32'd0);
        chk("flush_empty", 32'(EMPTY),      32'd1);
        chk("flush_waddr", 32'(RAM_A_ADDR), 32'd0);
        chk("flush_wen",   32'(RAM_A_WEN),  32'd1);
        adv();
        drain("flush");

        // Random handshakes, 10k samples
        acc = 0;
        c = 0;
        while (acc < 10000 && c < 60000) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 13'($urandom_range(0, 8190));
            drive(v, d, r);
            if (v && IN_READY) acc++;
            adv();
            c++;
        end
        chk("rand_accepts", 32'(acc), 32'd10000);
        drain("rand");

        // Reset for one cycle in the middle of a burst
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 13'(13'h100 + k), 1'b1);
            adv();
        end
        RESETN = 1'b0; poison_req = 1'b1;
        drive(1'b1, 13'h1F0, 1'b0);
        chk("mrst_in_ready", 32'(IN_READY),  32'd0);
        chk("mrst_a_wen",    32'(RAM_A_WEN), 32'd0);
        adv();
        RESETN = 1'b1; poison_req = 1'b0;
        exp_q.delete();
        drive(1'b1, 13'h200, 1'b1);
        chk("mrst_valid", 32'(OUT_VALID),  32'd0);
        chk("mrst_data",  32'(OUT_DATA),   32'd0);
        chk("mrst_level", 32'(LEVEL),      32'd0);
        chk("mrst_full",  32'(FULL),       32'd0);
        chk("mrst_empty", 32'(EMPTY),      32'd1);
        chk("mrst_waddr", 32'(RAM_A_ADDR), 32'd0);
        chk("mrst_wen",   32'(RAM_A_WEN),  32'd1);
        adv();
        for (int k = 1; k < 20; k++) begin
            drive(1'b1, 13'(13'h200 + k), 1'b1);
            adv();
        end
        drain("mrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dpsram_fifo_ctrl.md
DPSRAM_FIFO_CTRL -- requirements
Module: dpsram_fifo_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 13, sample width; ADDR_W, 7, RAM address width; DEPTH, 128, RAM entries (2**ADDR_W).
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK, in, 1: single clock, shared with the 128x13 DPSRAM.
- RESETN, in, 1: synchronous active-low reset.
- FLUSH, in, 1: synchronous clear of all contents.
- IN_DATA, in, DATA_W: upstream sample.
- IN_VALID, in, 1: upstream sample valid.
- IN_READY, out, 1: accepts sample this cycle.
- OUT_DATA, out, DATA_W: head sample.
- OUT_VALID, out, 1: OUT_DATA valid.
- OUT_READY, in, 1: downstream consumes head.
- RAM_A_ADDR, out, ADDR_W: DPSRAM port A (write) address.
- RAM_A_DIN, out, DATA_W: port A write data.
- RAM_A_WEN, out, 1: port A write enable.
- RAM_B_ADDR, out, ADDR_W: DPSRAM port B (read) address.
- RAM_B_DIN, out, DATA_W: tied 0.
- RAM_B_WEN, out, 1: tied 0.
- RAM_B_DOUT, in, DATA_W: port B read data, valid 1 CLK after RAM_B_ADDR.
- LEVEL, out, 8: total samples held (RAM + in-flight + output buffer), 0..DEPTH+2.
- FULL, out, 1: RAM holds DEPTH samples.
- EMPTY, out, 1: LEVEL==0.

Function
REQ-003 SHALL use port A only for writes and port B only for reads; DPSRAM read latency is exactly 1 cycle, with unregistered output.
REQ-004 SHALL accept a sample when IN_VALID and IN_READY are both high; in that cycle: RAM_A_WEN=1, RAM_A_ADDR=wr_ptr, RAM_A_DIN=IN_DATA, then wr_ptr increments mod DEPTH.
REQ-005 SHALL drive IN_READY = RESETN and not FULL and not FLUSH (combinational); RAM_A_WEN SHALL be 0 whenever no sample is accepted.
REQ-006 SHALL keep ram_count (0..DEPTH) = written minus issued-for-read; FULL = (ram_count==DEPTH).
REQ-007 SHALL hold a 2-entry output buffer (out_count 0..2) and a 1-bit rd_inflight flag.
REQ-008 SHALL issue a read (RAM_B_ADDR=rd_ptr, rd_ptr increments mod DEPTH, rd_inflight set next cycle) when ram_count>0 and out_count + rd_inflight - pop < 2, where pop = OUT_VALID and OUT_READY.
REQ-009 SHALL write RAM_B_DOUT into the output buffer in the cycle after issue; the buffer is strict FIFO order.
REQ-010 SHALL drive OUT_VALID = (out_count>0) and OUT_DATA = buffer head, both registered; the head SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-011 SHALL sustain 1 sample/cycle in and out simultaneously in steady state with OUT_READY held high.
REQ-012 Latency: a sample written to an empty FIFO at cycle t SHALL be readable (issued) at t+1 and appear on OUT_VALID/OUT_DATA at t+3.
REQ-013 Simultaneous accept and read-issue SHALL update ram_count by +1-1=0; FULL with a same-cycle issue SHALL still block the write, because IN_READY is computed from the pre-cycle count.
REQ-014 Port B SHALL never address an entry not yet written; same-address A-write/B-read in one cycle SHALL NOT occur.
REQ-015 Pointer wrap 127->0 SHALL be seamless with no lost or duplicated samples.
REQ-016 FLUSH=1 SHALL, at the clock edge, zero the pointers, ram_count, out_count and rd_inflight, discard any in-flight read data, and accept no write that cycle.
REQ-017 LEVEL SHALL be registered and equal ram_count + rd_inflight + out_count.

Reset
REQ-018 With RESETN low at a CLK edge, all state SHALL clear: pointers 0, counts 0, OUT_VALID 0, OUT_DATA 0, LEVEL 0, FULL 0, EMPTY 1, RAM_A_WEN 0, IN_READY 0 while RESETN is low.
REQ-019 RESETN SHALL take priority over FLUSH; RAM contents are not cleared and SHALL never be read before being rewritten.
REQ-020 Reset asserted mid-stream SHALL drop all held samples; the first post-reset write SHALL go to address 0.

Verification
REQ-021 Write 0x001 at t, OUT_READY=1 -> RAM_B_ADDR=0 issued at t+1; OUT_VALID=1, OUT_DATA=0x001 at t+3; then EMPTY=1.
REQ-022 Write 130 samples 0..129 with OUT_READY=0 -> IN_READY drops after 130 accepts (RAM 128 + output buffer 2), FULL=1, LEVEL=130; release OUT_READY -> 0..129 out in order.
REQ-023 Continuous 300 samples in/out, both sides always ready -> 1 sample/cycle after fill, order preserved across two pointer wraps.
REQ-024 Random IN_VALID/OUT_READY (50%), 10k samples -> scoreboard match, LEVEL never exceeds 130, no read of an unwritten address.
REQ-025 FLUSH with LEVEL=5 and a read in flight -> next cycle LEVEL=0, OUT_VALID=0; next write lands at address 0.
REQ-026 RESETN low for 1 cycle mid-burst -> all outputs at reset values; the stream restarts cleanly.
